// File: rtl/accumulator_drain_controller_if.sv
// Handshake and data bundle for accumulator_drain_controller.
// Groups the drain request, the shared accumulator read port and the output stream.
// Optional: ACC_DRAIN_PERF_EN adds perf_stall_o (stall cycles caused by compute reads).
// master: drives start/mac/read-data/ready, observes the rest.
// slave : the drain controller itself.
interface accumulator_drain_controller_if #(
  parameter int MUL_SIZE = 32,
  parameter int ACC_W    = 32,
  parameter int ADDR_W   = 10
);
  logic                      start_i;
  logic [ADDR_W-1:0]         base_addr_i;
  logic [ADDR_W-1:0]         num_rows_i;
  logic                      mac_rd_en_i;
  logic [ADDR_W-1:0]         mac_rd_addr_i;
  logic                      acc_rd_en_o;
  logic [ADDR_W-1:0]         acc_rd_addr_o;
  logic [MUL_SIZE*ACC_W-1:0] acc_rd_data_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [MUL_SIZE*ACC_W-1:0] out_data_o;
  logic                      out_last_o;
  logic                      busy_o;
  logic                      done_o;
`ifdef ACC_DRAIN_PERF_EN
  logic [15:0]               perf_stall_o;
`endif

  modport master (
    output start_i, base_addr_i, num_rows_i, mac_rd_en_i, mac_rd_addr_i,
    output acc_rd_data_i, out_ready_i,
    input  acc_rd_en_o, acc_rd_addr_o, out_valid_o, out_data_o, out_last_o,
    input  busy_o, done_o
`ifdef ACC_DRAIN_PERF_EN
    , input perf_stall_o
`endif
  );

  modport slave (
    input  start_i, base_addr_i, num_rows_i, mac_rd_en_i, mac_rd_addr_i,
    input  acc_rd_data_i, out_ready_i,
    output acc_rd_en_o, acc_rd_addr_o, out_valid_o, out_data_o, out_last_o,
    output busy_o, done_o
`ifdef ACC_DRAIN_PERF_EN
    , output perf_stall_o
`endif
  );
endinterface

// File: rtl/accumulator_drain_controller.sv
// Drains finished accumulator rows through a small credit-managed FIFO onto a valid/ready stream.
// Latency: start to first out_valid_o = 2 + RD_LATENCY cycles with no compute reads; 1 row/cycle.
// Backpressure: reads issue only while in-flight tags + FIFO fill < FIFO_DEPTH; compute reads win the port.
// Ports: clk_i/rst_i (async active-high) plus bus (slave modport): start/base/rows request,
// muxed accumulator read port, out_valid/ready/data/last stream, busy/done status.
// Optional: define ACC_DRAIN_PERF_EN for perf_stall_o, a saturating count of compute-blocked issues.
module accumulator_drain_controller #(
  parameter int MUL_SIZE   = 32,
  parameter int ACC_W      = 32,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  accumulator_drain_controller_if.slave bus
);
  localparam int DATA_W = MUL_SIZE * ACC_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W  = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_FLUSH, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       rows_q, rows_d;
  logic [ADDR_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]       accept_cnt_q, accept_cnt_d;
  logic [RD_LATENCY-1:0]   tag_q, tag_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       fifo_mem_q [FIFO_DEPTH];

  logic [OUT_W-1:0]        outstanding;
  logic                    credit_ok;
  logic                    drain_issue;
  logic                    push;
  logic                    pop;
  logic                    out_vld;

  // Every tag still in the pipe holds a FIFO slot, including the one landing this cycle.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + OUT_W'(tag_q[i]);
    end
  end

  assign credit_ok   = (int'(outstanding) + int'(fifo_cnt_q)) < FIFO_DEPTH;
  assign drain_issue = (state_q == ST_ISSUE) && !bus.mac_rd_en_i && credit_ok;
  assign push        = tag_q[RD_LATENCY-1];
  assign out_vld     = (fifo_cnt_q != '0);
  assign pop         = out_vld && bus.out_ready_i;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rows_d       = rows_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;

    tag_d    = tag_q << 1;
    tag_d[0] = drain_issue;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      accept_cnt_d = accept_cnt_q + ADDR_W'(1);
    end
    // Push and pop together leave the fill level alone, even when full.
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          base_d       = bus.base_addr_i;
          rows_d       = bus.num_rows_i;
          issue_cnt_d  = '0;
          accept_cnt_d = '0;
          state_d      = (bus.num_rows_i == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (drain_issue) begin
          issue_cnt_d = issue_cnt_q + ADDR_W'(1);
          if (issue_cnt_q == rows_q - ADDR_W'(1)) state_d = ST_FLUSH;
        end
      end
      // Looking at the post-transfer count lets done follow the last beat directly.
      ST_FLUSH: begin
        if (accept_cnt_d == rows_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // busy stays up through the done cycle and falls together with done.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

`ifdef ACC_DRAIN_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE && bus.start_i) begin
      perf_d = '0;
    end else if (state_q == ST_ISSUE && bus.mac_rd_en_i && credit_ok && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  assign bus.perf_stall_o = perf_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      rows_q       <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef ACC_DRAIN_PERF_EN
      perf_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      rows_q       <= rows_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef ACC_DRAIN_PERF_EN
      perf_q       <= perf_d;
`endif
    end
  end

  // Row storage needs no reset: nothing reads it while the fill count is zero.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.acc_rd_data_i;
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

  assign bus.acc_rd_en_o   = bus.mac_rd_en_i || drain_issue;
  assign bus.acc_rd_addr_o = bus.mac_rd_en_i ? bus.mac_rd_addr_i : (base_q + issue_cnt_q);
  assign bus.out_valid_o   = out_vld;
  // Masked so the data bus reads zero whenever nothing is offered.
  assign bus.out_data_o    = out_vld ? fifo_mem_q[rd_ptr_q] : '0;
  assign bus.out_last_o    = out_vld && (accept_cnt_q == rows_q - ADDR_W'(1));
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
endmodule

// File: tb/tb_accumulator_drain_controller.sv
// Directed bench for accumulator_drain_controller: table of drain scenarios plus reset-abort sequence.
// An accumulator model returns row_of(addr) RD_LATENCY cycles after each read enable.
module tb_accumulator_drain_controller;
  localparam int MUL_SIZE   = 32;
  localparam int ACC_W      = 32;
  localparam int ADDR_W     = 10;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = MUL_SIZE * ACC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accumulator_drain_controller_if #(.MUL_SIZE(MUL_SIZE), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus();

  accumulator_drain_controller #(
    .MUL_SIZE(MUL_SIZE), .ACC_W(ACC_W), .ADDR_W(ADDR_W),
    .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [DW-1:0] row_of(input logic [ADDR_W-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < MUL_SIZE; i++) r[i*ACC_W +: ACC_W] = {12'hACC, 10'(i), a};
    return r;
  endfunction

  // Accumulator model: {en, addr} delayed RD_LATENCY cycles, data from the delayed address.
  logic [ADDR_W:0] rd_pipe [RD_LATENCY];
  always @(posedge clk) begin
    rd_pipe[0] <= {bus.acc_rd_en_o, bus.acc_rd_addr_o};
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.acc_rd_data_i = row_of(rd_pipe[RD_LATENCY-1][ADDR_W-1:0]);

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got[127:0], exp[127:0]);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rows;
    int                ready_off;       // out_ready_i low for cycles [0, ready_off)
    bit                mac_alt;         // compute reads on odd cycles 1..15
    int                exp_first_vld;   // cycle of first out_valid_o, -1 = never
    int                exp_done;        // cycle of the done_o pulse
    int                exp_busy;        // cycles with busy_o high
    int                exp_reads;       // drain reads issued
    int                exp_stall_reads; // drain reads issued while ready was low
    int                exp_perf;
  } vec_t;

  vec_t vecs [5];

  // Cycle 0 is the start_i cycle; inputs change at negedge, outputs sampled 1ns later.
  task automatic run_vec(input vec_t v, input string nm);
    int nreads = 0, stall_reads = 0, nbeats = 0, busy_cnt = 0, done_cnt = 0;
    int done_t = -1, first_vld = -1;
    bit mac;
    logic [ADDR_W-1:0] ea;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      bus.start_i       = (t == 0);
      bus.base_addr_i   = v.base;
      bus.num_rows_i    = v.rows;
      mac               = v.mac_alt && (t % 2 == 1) && (t <= 15);
      bus.mac_rd_en_i   = mac;
      bus.mac_rd_addr_i = 10'h200;
      bus.out_ready_i   = (t >= v.ready_off);
      #1;
      if (mac) begin
        chk({nm, " mac_en"}, bus.acc_rd_en_o, 1);
        chk({nm, " mac_addr"}, bus.acc_rd_addr_o, 10'h200);
      end else if (bus.acc_rd_en_o) begin
        ea = v.base + ADDR_W'(nreads);
        chk({nm, " drain_addr"}, bus.acc_rd_addr_o, ea);
        nreads++;
        if (t < v.ready_off) stall_reads++;
      end
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        if (done_cnt == 0) done_t = t;
        done_cnt++;
      end
      if (bus.out_valid_o) begin
        if (first_vld < 0) first_vld = t;
        ea = v.base + ADDR_W'(nbeats);
        chk({nm, " data"}, bus.out_data_o, row_of(ea));
        if (bus.out_ready_i) begin
          chk({nm, " last"}, bus.out_last_o, (nbeats == int'(v.rows) - 1));
          nbeats++;
        end
      end
      if (done_t >= 0 && t >= done_t + 2) break;
    end
    chk({nm, " first_valid_cycle"}, first_vld, v.exp_first_vld);
    chk({nm, " done_cycle"}, done_t, v.exp_done);
    chk({nm, " done_pulses"}, done_cnt, 1);
    chk({nm, " busy_cycles"}, busy_cnt, v.exp_busy);
    chk({nm, " reads"}, nreads, v.exp_reads);
    chk({nm, " reads_while_stalled"}, stall_reads, v.exp_stall_reads);
    chk({nm, " beats"}, nbeats, int'(v.rows));
`ifdef ACC_DRAIN_PERF_EN
    chk({nm, " perf_stall"}, bus.perf_stall_o, v.exp_perf);
`endif
    bus.mac_rd_en_i = 1'b0;
    bus.out_ready_i = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, " out_valid"}, bus.out_valid_o, 0);
    chk({nm, " out_last"}, bus.out_last_o, 0);
    chk({nm, " out_data"}, bus.out_data_o, 0);
    chk({nm, " busy"}, bus.busy_o, 0);
    chk({nm, " done"}, bus.done_o, 0);
    chk({nm, " acc_rd_en"}, bus.acc_rd_en_o, 0);
    chk({nm, " acc_rd_addr"}, bus.acc_rd_addr_o, 0);
  endtask

  initial begin
    int spurious;
    vecs[0] = '{base: 10'h010, rows: 10'd4, ready_off: 0,  mac_alt: 1'b0, exp_first_vld: 4,
                exp_done: 8,  exp_busy: 8,  exp_reads: 4, exp_stall_reads: 0, exp_perf: 0};
    vecs[1] = '{base: 10'h020, rows: 10'd0, ready_off: 0,  mac_alt: 1'b0, exp_first_vld: -1,
                exp_done: 1,  exp_busy: 1,  exp_reads: 0, exp_stall_reads: 0, exp_perf: 0};
    vecs[2] = '{base: 10'h3FE, rows: 10'd4, ready_off: 0,  mac_alt: 1'b0, exp_first_vld: 4,
                exp_done: 8,  exp_busy: 8,  exp_reads: 4, exp_stall_reads: 0, exp_perf: 0};
    vecs[3] = '{base: 10'h040, rows: 10'd8, ready_off: 0,  mac_alt: 1'b1, exp_first_vld: 5,
                exp_done: 20, exp_busy: 20, exp_reads: 8, exp_stall_reads: 0, exp_perf: 8};
    vecs[4] = '{base: 10'h100, rows: 10'd8, ready_off: 10, mac_alt: 1'b0, exp_first_vld: 4,
                exp_done: 18, exp_busy: 18, exp_reads: 8, exp_stall_reads: 4, exp_perf: 0};

    rst               = 1'b0;
    bus.start_i       = 1'b0;
    bus.base_addr_i   = '0;
    bus.num_rows_i    = '0;
    bus.mac_rd_en_i   = 1'b0;
    bus.mac_rd_addr_i = '0;
    bus.out_ready_i   = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk_outputs_zero("reset");
`ifdef ACC_DRAIN_PERF_EN
    chk("reset perf_stall", bus.perf_stall_o, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_vec(vecs[0], "basic");
    run_vec(vecs[1], "zero_rows");
    run_vec(vecs[2], "wrap");
    run_vec(vecs[3], "mac_alt");
    run_vec(vecs[4], "backpressure");

    // Reset in FLUSH with two reads still in flight; released before the next edge so
    // their returns arrive while the DUT is idle.
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.base_addr_i = 10'h080;
    bus.num_rows_i  = 10'd4;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    #1;
    chk("abort pre_reset valid", bus.out_valid_o, 1);
    chk("abort pre_reset busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("abort");
    #1 rst = 1'b0;
    spurious = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid_o || bus.busy_o || bus.done_o) spurious++;
    end
    chk("abort spurious_activity", spurious, 0);
    run_vec(vecs[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
